// File: rtl/uartb_boot_ctrl.sv
// uartb_boot_ctrl -- bootloader protocol engine between uartb_rx and uartb_tx.
//
// Parses a framed program image from the received byte stream:
//   SYNC, LEN_LO, LEN_HI, LEN little-endian 32-bit words, CSUM
// where CSUM is the modulo-256 sum of the payload bytes. Each assembled
// word is written to instruction memory at BASE_ADDR + word index. The CPU
// stays in reset until a frame passes its checksum. The host then receives
// a one-byte ACK. A bad checksum or an oversize length gets a NAK instead.
// A stalled frame is abandoned after TIMEOUT_CYC idle cycles.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   rx_done_tick  one-cycle byte-valid strobe from uartb_rx
//   rx_data       received byte, valid with rx_done_tick
//   tx_done_tick  one-cycle strobe from uartb_tx at stop-bit completion
//   tx_start      one-cycle transmit request to uartb_tx
//   tx_data       byte to transmit, held from tx_start until tx_done_tick
//   mem_we        one-cycle instruction-memory write strobe
//   mem_addr      instruction-memory word address
//   mem_wdata     instruction-memory write data
//   cpu_rst       1 = hold the CPU in reset
//   boot_busy     1 while a frame or its response is in progress
//   boot_done     1 after an ACK has been sent, cleared by the next SYNC
//   boot_err      sticky error (NAK or timeout), cleared by the next SYNC
module uartb_boot_ctrl #(
  parameter int          ADDR_W      = 12,
  parameter int          BASE_ADDR   = 0,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  NAK_BYTE    = 8'h45,
  parameter int          TIMEOUT_CYC = 2_700_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              boot_busy,
  output logic              boot_done,
  output logic              boot_err
);

  // The word index is 16 bits wide, so ADDR_W is limited to 16.
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]       MAX_LEN  = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RESP, S_WAIT_TX, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       len, len_nxt;
  logic [15:0]       idx, idx_nxt;
  logic [1:0]        byte_cnt, byte_cnt_nxt;
  logic [23:0]       shreg, shreg_nxt;      // three most recent payload bytes
  logic [7:0]        csum, csum_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic              send_ack, send_ack_nxt;
  logic              tx_start_nxt;
  logic [7:0]        tx_data_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [31:0]       mem_wdata_nxt;
  logic              cpu_rst_nxt, boot_done_nxt, boot_err_nxt;

  logic [15:0] len_full;   // LEN as seen when its high byte arrives
  logic [31:0] asm_word;   // word completed if the current byte is its 4th
  logic        timed;      // states guarded by the inter-byte timeout

  assign len_full  = {rx_data, len[7:0]};
  assign asm_word  = {rx_data, shreg};
  assign timed     = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CSUM);
  assign boot_busy = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt     = state;
    len_nxt       = len;
    idx_nxt       = idx;
    byte_cnt_nxt  = byte_cnt;
    shreg_nxt     = shreg;
    csum_nxt      = csum;
    tmo_cnt_nxt   = '0;
    send_ack_nxt  = send_ack;
    tx_start_nxt  = 1'b0;
    tx_data_nxt   = tx_data;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cpu_rst_nxt   = cpu_rst;
    boot_done_nxt = boot_done;
    boot_err_nxt  = boot_err;

    // Inter-byte timeout. A byte on the final cycle takes priority, and the
    // counter is zero on entry because every entry into a timed state
    // happens on a consumed byte.
    if (timed && !rx_done_tick) begin
      if (tmo_cnt == TMO_LAST) begin
        boot_err_nxt = 1'b1;
        state_nxt    = S_IDLE;
      end else begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
      end
    end

    unique case (state)
      S_IDLE, S_DONE: begin
        if (rx_done_tick && rx_data == SYNC_BYTE) begin
          state_nxt     = S_LEN0;
          cpu_rst_nxt   = 1'b1;
          boot_done_nxt = 1'b0;
          boot_err_nxt  = 1'b0;
          csum_nxt      = '0;
          idx_nxt       = '0;
          byte_cnt_nxt  = '0;
        end
      end

      S_LEN0: begin
        if (rx_done_tick) begin
          len_nxt   = {8'h00, rx_data};
          state_nxt = S_LEN1;
        end
      end

      S_LEN1: begin
        if (rx_done_tick) begin
          len_nxt = len_full;
          if (17'(len_full) > MAX_LEN) begin
            send_ack_nxt = 1'b0;
            boot_err_nxt = 1'b1;
            state_nxt    = S_RESP;
          end else if (len_full == 16'd0) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (rx_done_tick) begin
          shreg_nxt    = asm_word[31:8];
          csum_nxt     = csum + rx_data;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = BASE_W + idx[ADDR_W-1:0];
            mem_wdata_nxt = asm_word;
            idx_nxt       = idx + 16'd1;
            if (idx == len - 16'd1) state_nxt = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (rx_done_tick) begin
          send_ack_nxt = (rx_data == csum);
          if (rx_data != csum) boot_err_nxt = 1'b1;
          state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = send_ack ? ACK_BYTE : NAK_BYTE;
        state_nxt    = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (tx_done_tick) begin
          if (send_ack) begin
            boot_done_nxt = 1'b1;
            cpu_rst_nxt   = 1'b0;
            state_nxt     = S_DONE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      csum      <= '0;
      tmo_cnt   <= '0;
      send_ack  <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shreg     <= shreg_nxt;
      csum      <= csum_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      send_ack  <= send_ack_nxt;
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_rst   <= cpu_rst_nxt;
      boot_done <= boot_done_nxt;
      boot_err  <= boot_err_nxt;
    end
  end

endmodule

// File: tb/tb_uartb_boot_ctrl.sv
// Testbench for uartb_boot_ctrl: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_uartb_boot_ctrl;

  localparam int         ADDR_W    = 12;
  localparam int         BASE_ADDR = 0;
  localparam int         TMO       = 300;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] ACK       = 8'h4B;
  localparam logic [7:0] NAK       = 8'h45;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic              tx_done_tick;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              boot_busy;
  logic              boot_done;
  logic              boot_err;

  uartb_boot_ctrl #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SYNC_BYTE(SYNC),
    .ACK_BYTE(ACK), .NAK_BYTE(NAK), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .boot_busy(boot_busy),
    .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed DUT activity, sampled on the falling edge.
  int                wr_cyc_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [7:0]        tx_q[$];
  int                byte_cyc[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (tx_start) tx_q.push_back(tx_data);
  end

  // Reference model state.
  logic [7:0]        frame_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [7:0]        exp_resp;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    rx_data      = 8'($urandom);
    byte_cyc.push_back(cyc);
  endtask

  // Frame-level model: expected writes and response byte for frame_q.
  task automatic model_frame();
    int          len;
    logic [7:0]  sum;
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    len = int'(frame_q[1]) + 256 * int'(frame_q[2]);
    if (len > (1 << ADDR_W)) begin
      exp_resp = NAK;
    end else begin
      sum = 8'd0;
      for (int i = 0; i < len; i++) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
          w   = w | (32'(frame_q[3 + 4 * i + k]) << (8 * k));
          sum = sum + frame_q[3 + 4 * i + k];
        end
        exp_addr_q.push_back(ADDR_W'((BASE_ADDR + i) % (1 << ADDR_W)));
        exp_data_q.push_back(w);
      end
      exp_resp = (frame_q[3 + 4 * len] == sum) ? ACK : NAK;
    end
  endtask

  task automatic build_frame(input int len, input bit bad);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'd0;
    frame_q.delete();
    frame_q.push_back(SYNC);
    frame_q.push_back(8'(len));
    frame_q.push_back(8'(len >> 8));
    if (len > (1 << ADDR_W)) return;
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      sum = sum + b;
    end
    if (bad) sum = sum + 8'($urandom_range(1, 255));
    frame_q.push_back(sum);
  endtask

  // Sends frame_q (skipping bytes already sent), answers the response and
  // compares writes, response and final status with the model.
  task automatic run_frame(input string name, input int skip);
    int waited;
    int bi;
    model_frame();
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    byte_cyc.delete();
    for (int i = skip; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      gap($urandom_range(0, 2));
    end
    waited = 0;
    while (tx_q.size() == 0 && waited < 40) begin
      step();
      waited++;
    end
    check({name, " tx_start count"}, 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) check({name, " tx_data"}, 32'(tx_q[0]), 32'(exp_resp));
    // A byte arriving while the response is in flight must be dropped.
    gap(1);
    send_byte(SYNC);
    gap($urandom_range(0, 3));
    check({name, " tx_data held"}, 32'(tx_data), 32'(exp_resp));
    check({name, " busy in tx"}, 32'(boot_busy), 32'd1);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    step();
    check({name, " boot_done"}, 32'(boot_done), (exp_resp == ACK) ? 32'd1 : 32'd0);
    check({name, " cpu_rst"}, 32'(cpu_rst), (exp_resp == ACK) ? 32'd0 : 32'd1);
    check({name, " boot_err"}, 32'(boot_err), (exp_resp == ACK) ? 32'd0 : 32'd1);
    check({name, " busy after"}, 32'(boot_busy), 32'd0);
    check({name, " tx_start once"}, 32'(tx_q.size()), 32'd1);
    check({name, " wr count"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check({name, " wr addr"}, 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
      check({name, " wr data"}, wr_data_q[i], exp_data_q[i]);
      bi = 6 + 4 * i - skip;
      if (bi >= 0 && bi < byte_cyc.size())
        check({name, " wr latency"}, 32'(wr_cyc_q[i]), 32'(byte_cyc[bi]));
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, " tx_start"}, 32'(tx_start), 32'd0);
    check({name, " tx_data"}, 32'(tx_data), 32'd0);
    check({name, " mem_we"}, 32'(mem_we), 32'd0);
    check({name, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, " mem_wdata"}, mem_wdata, 32'd0);
    check({name, " cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({name, " boot_busy"}, 32'(boot_busy), 32'd0);
    check({name, " boot_done"}, 32'(boot_done), 32'd0);
    check({name, " boot_err"}, 32'(boot_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nb;
    int         len;
    rst          = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'd0;
    tx_done_tick = 1'b0;
    gap(3);
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Good frame from the test plan.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4B};
    run_frame("good", 0);
    if (wr_data_q.size() == 2) begin
      check("good word0", wr_data_q[0], 32'h0000_0013);
      check("good word1", wr_data_q[1], 32'hDEAD_BEEF);
    end

    // Noise after DONE is ignored; SYNC restarts the boot.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("noise boot_done", 32'(boot_done), 32'd1);
    check("noise cpu_rst", 32'(cpu_rst), 32'd0);
    send_byte(SYNC);
    check("reload cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload boot_done", 32'(boot_done), 32'd0);
    check("reload busy", 32'(boot_busy), 32'd1);
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero_len", 1);

    // Timeout mid-frame.
    tx_q.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    gap(TMO - 2);
    check("tmo early err", 32'(boot_err), 32'd0);
    check("tmo early busy", 32'(boot_busy), 32'd1);
    gap(3);
    check("tmo err", 32'(boot_err), 32'd1);
    check("tmo busy", 32'(boot_busy), 32'd0);
    check("tmo cpu_rst", 32'(cpu_rst), 32'd1);
    check("tmo no tx", 32'(tx_q.size()), 32'd0);
    build_frame(3, 1'b0);
    run_frame("after_tmo", 0);

    // Bad checksum and oversize frames.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    run_frame("bad_csum", 0);
    frame_q = '{8'hA5, 8'h01, 8'h10};
    run_frame("oversize", 0);
    build_frame(1 << ADDR_W, 1'b0);
    frame_q = '{8'hA5, 8'h00, 8'h10};
    model_frame();
    check("max len not oversize", (exp_resp == NAK) ? 32'd0 : 32'd1, 32'd1);

    // Randomized frames.
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        nb = 8'($urandom);
        if (nb == SYNC) nb = 8'h00;
        send_byte(nb);
      end
      if ($urandom_range(0, 9) == 0) len = (1 << ADDR_W) + 1 + int'($urandom_range(0, 60000));
      else len = int'($urandom_range(0, 6));
      build_frame(len, $urandom_range(0, 3) == 0);
      run_frame("rand", 0);
    end

    // Reset during DATA.
    build_frame(2, 1'b0);
    run_frame("pre_rst", 0);
    tx_q.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    rst = 1'b1;
    step();
    check_reset_values("mid_rst");
    rst = 1'b0;
    wr_addr_q.delete();
    send_byte(8'h00);
    send_byte(8'h00);
    gap(5);
    check("mid_rst no write", 32'(wr_addr_q.size()), 32'd0);
    check("mid_rst no tx", 32'(tx_q.size()), 32'd0);
    check("mid_rst idle", 32'(boot_busy), 32'd0);

    build_frame(3, 1'b0);
    run_frame("final", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
